uart_fifo_ctrl: RTL and testbench

//  Next-generation CSR controller between the Wishbone slave decode and the uart_receive/uart_transmission cores.

---
 rtl/uart_fifo_ctrl_pkg.sv | 25 ++
 rtl/uart_fifo_ctrl_sync_fifo.sv | 43 ++++
 rtl/uart_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_ctrl_pkg.sv
// uart_fifo_ctrl_pkg: register map, STATUS/CTRL bit positions, TX FSM states and reset divisor
package uart_fifo_ctrl_pkg;
   localparam logic [15:0] UART_DEFAULT_DIV = 16'd4167;
   localparam logic [2:0] ADR_RXDATA = 3'd0;
   localparam logic [2:0] ADR_TXDATA = 3'd1;
   localparam logic [2:0] ADR_STATUS = 3'd2;
   localparam logic [2:0] ADR_CTRL   = 3'd3;
   localparam logic [2:0] ADR_CLKDIV = 3'd4;
   localparam int ST_RX_EMPTY = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_EMPTY = 2;
   localparam int ST_TX_FULL  = 3;
   localparam int ST_RX_OVR   = 4;
   localparam int ST_FRM_ERR  = 5;
   localparam int ST_TX_OVF   = 6;
   localparam int ST_TX_BUSY  = 7;
   localparam int CT_RX_IRQ_EN  = 0;
   localparam int CT_TX_IRQ_EN  = 1;
   localparam int CT_ERR_IRQ_EN = 2;
   typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT} tx_state_t;
   // a zero threshold would fire on an empty FIFO, so it behaves as one
   function automatic logic [7:0] eff_thresh(input logic [7:0] t);
      return (t == 8'd0) ? 8'd1 : t;
   endfunction
endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// uart_fifo_ctrl_sync_fifo: single-clock FIFO with LW-bit wrapping pointers
//  clk, rst_n      clock, async active-low reset
//  push, din       write request and data (accepted when not full, or when popping the same cycle)
//  pop, dout       read request (ignored when empty) and head-of-queue data
//  full, empty     occupancy flags
//  level           entry count, $clog2(DEPTH)+1 bits
module uart_fifo_ctrl_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [LW-1:0] wptr, rptr;
   logic do_push, do_pop;
   assign do_pop  = pop & ~empty;
   // a pop frees a slot in the same cycle, so a push into a full FIFO still lands
   assign do_push = push & (~full | do_pop);
   assign full    = (wptr[LW-1] != rptr[LW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = wptr == rptr;
   assign level   = wptr - rptr;
   assign dout    = mem[rptr[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + LW'(1);
         if (do_pop) rptr <= rptr + LW'(1);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: CSR block between Wishbone decode and the UART rx/tx cores
//  i_wb_*/o_wb_*        single-cycle-ack register port, map decoded from adr[4:2]
//  i_rx_data/valid      received byte strobe; i_frame_err marks a bad stop bit
//  o_tx_data/o_tx_start level request to transmitter; i_tx_start_clear, i_tx_busy handshake
//  o_clk_div            baud divisor; o_irq registered level interrupt
module uart_fifo_ctrl
   import uart_fifo_ctrl_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_wb_valid,
   input  logic [31:0] i_wb_adr,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_dat,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   input  logic        i_frame_err,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_start,
   input  logic        i_tx_start_clear,
   input  logic        i_tx_busy,
   output logic [15:0] o_clk_div,
   output logic        o_irq
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   tx_state_t state, state_nx;
   logic acc, rx_push, rx_pop, tx_wr, tx_pop, irq_nx;
   logic [2:0] adr, w1c, irq_en;
   logic [7:0] rx_dout, tx_dout, rx_thresh;
   logic rx_full, rx_empty, tx_full, tx_empty;
   logic [LW-1:0] rx_level, tx_level;
   logic rx_ovr, frm_err, tx_ovf;
   logic [15:0] div_nx;
   logic [31:0] status, rdata;
   logic unused;
   assign unused = ^{i_wb_adr[31:5], i_wb_adr[1:0], i_wb_dat[31:16]};
   // the ack cycle blocks a new access, so every access is seen exactly once
   assign acc     = i_wb_valid & ~o_wb_ack;
   assign adr     = i_wb_adr[4:2];
   assign rx_pop  = acc & ~i_wb_we & (adr == ADR_RXDATA) & ~rx_empty;
   assign tx_wr   = acc & i_wb_we & (adr == ADR_TXDATA) & i_wb_sel[0];
   assign rx_push = i_rx_valid & ~i_frame_err;
   assign tx_pop  = (state == TX_IDLE) & ~tx_empty & ~i_tx_busy;
   assign w1c     = (acc & i_wb_we & (adr == ADR_STATUS)) ? i_wb_dat[6:4] : 3'b0;
   assign div_nx  = {i_wb_sel[1] ? i_wb_dat[15:8] : o_clk_div[15:8],
                     i_wb_sel[0] ? i_wb_dat[7:0]  : o_clk_div[7:0]};
   uart_fifo_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .din(i_rx_data),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level));
   uart_fifo_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(tx_wr), .pop(tx_pop), .din(i_wb_dat[7:0]),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level));
   always_comb begin
      status = '0;
      status[ST_RX_EMPTY] = rx_empty;
      status[ST_RX_FULL]  = rx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_TX_FULL]  = tx_full;
      status[ST_RX_OVR]   = rx_ovr;
      status[ST_FRM_ERR]  = frm_err;
      status[ST_TX_OVF]   = tx_ovf;
      status[ST_TX_BUSY]  = i_tx_busy;
      status[15:8]        = 8'(rx_level);
      status[23:16]       = 8'(tx_level);
   end
   always_comb
      rdata = (adr == ADR_RXDATA) ? (rx_empty ? 32'h0 : {23'h0, 1'b1, rx_dout}) :
              (adr == ADR_STATUS) ? status :
              (adr == ADR_CTRL)   ? {16'h0, rx_thresh, 5'h0, irq_en} :
              (adr == ADR_CLKDIV) ? {16'h0, o_clk_div} : 32'h0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         o_wb_ack  <= 1'b0;
         o_wb_dat  <= '0;
         irq_en    <= '0;
         rx_thresh <= '0;
         o_clk_div <= DEFAULT_DIV;
      end else begin
         o_wb_ack <= acc;
         if (acc & ~i_wb_we) o_wb_dat <= rdata;
         if (acc & i_wb_we & (adr == ADR_CTRL) & i_wb_sel[0]) irq_en <= i_wb_dat[2:0];
         if (acc & i_wb_we & (adr == ADR_CTRL) & i_wb_sel[1]) rx_thresh <= i_wb_dat[15:8];
         if (acc & i_wb_we & (adr == ADR_CLKDIV) & (div_nx != 16'h0)) o_clk_div <= div_nx;
      end
   // a new error in the same cycle as its W1C wins, so no event is lost
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_ovr  <= 1'b0;
         frm_err <= 1'b0;
         tx_ovf  <= 1'b0;
      end else begin
         rx_ovr  <= (rx_ovr & ~w1c[0]) | (rx_push & rx_full & ~rx_pop);
         frm_err <= (frm_err & ~w1c[1]) | i_frame_err;
         tx_ovf  <= (tx_ovf & ~w1c[2]) | (tx_wr & tx_full & ~tx_pop);
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= TX_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         TX_IDLE: if (tx_pop) state_nx = TX_REQ;
         TX_REQ:  if (i_tx_start_clear) state_nx = TX_WAIT;
         default: if (!i_tx_busy) state_nx = TX_IDLE;
      endcase
   end
   always_comb o_tx_start = state == TX_REQ;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) o_tx_data <= '0;
      else if (tx_pop) o_tx_data <= tx_dout;
   always_comb
      irq_nx = (irq_en[CT_RX_IRQ_EN] & (16'(rx_level) >= 16'(eff_thresh(rx_thresh)))) |
               (irq_en[CT_TX_IRQ_EN] & tx_empty & (state == TX_IDLE)) |
               (irq_en[CT_ERR_IRQ_EN] & (rx_ovr | frm_err | tx_ovf));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) o_irq <= 1'b0;
      else o_irq <= irq_nx;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed plus randomized checks of uart_fifo_ctrl against a queue-based model
module tb_uart_fifo_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic i_wb_valid = 0, i_wb_we = 0;
   logic [31:0] i_wb_adr = 0, i_wb_dat = 0;
   logic [3:0] i_wb_sel = 0;
   logic o_wb_ack;
   logic [31:0] o_wb_dat;
   logic [7:0] i_rx_data = 0;
   logic i_rx_valid = 0, i_frame_err = 0;
   logic [7:0] o_tx_data;
   logic o_tx_start;
   logic i_tx_start_clear = 0, i_tx_busy = 0;
   logic [15:0] o_clk_div;
   logic o_irq;
   int compared = 0, mismatched = 0;
   logic [7:0] rxq[$], txq[$];
   bit m_rx_ovr, m_frm, m_tx_ovf, tx_idle;
   logic [2:0] m_en;
   logic [7:0] m_thr;
   logic [15:0] m_div;

   uart_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_wb_valid(i_wb_valid), .i_wb_adr(i_wb_adr), .i_wb_we(i_wb_we),
      .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .o_wb_ack(o_wb_ack), .o_wb_dat(o_wb_dat),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_frame_err(i_frame_err),
      .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_start_clear(i_tx_start_clear),
      .i_tx_busy(i_tx_busy), .o_clk_div(o_clk_div), .o_irq(o_irq));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rxq.delete();
      txq.delete();
      m_rx_ovr = 0; m_frm = 0; m_tx_ovf = 0; tx_idle = 1;
      m_en = 0; m_thr = 0; m_div = 16'd4167;
   endtask

   function automatic logic [31:0] m_status();
      return {8'h0, 8'(txq.size()), 8'(rxq.size()), i_tx_busy, m_tx_ovf, m_frm, m_rx_ovr,
              txq.size() == 16, txq.size() == 0, rxq.size() == 16, rxq.size() == 0};
   endfunction

   function automatic bit m_irq();
      int thr;
      thr = (m_thr == 0) ? 1 : int'(m_thr);
      return (m_en[0] && rxq.size() >= thr) || (m_en[1] && txq.size() == 0 && tx_idle) ||
             (m_en[2] && (m_rx_ovr || m_frm || m_tx_ovf));
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
      logic got;
      @(negedge clk);
      i_wb_valid = 1; i_wb_we = we; i_wb_adr = {27'h0, a, 2'b00}; i_wb_dat = d; i_wb_sel = s;
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(posedge clk);
         #1;
         got = o_wb_ack;
      end
      r = o_wb_dat;
      i_wb_valid = 0;
      check("bus_ack", got, 1);
   endtask

   task automatic access(input logic we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                         input string tag);
      logic [31:0] r, e;
      logic [15:0] nd;
      logic [7:0] b;
      e = 0;
      if (!we)
         case (a)
            3'd0: if (rxq.size() != 0) begin b = rxq.pop_front(); e = {23'h0, 1'b1, b}; end
            3'd2: e = m_status();
            3'd3: e = {16'h0, m_thr, 5'h0, m_en};
            3'd4: e = {16'h0, m_div};
            default: e = 0;
         endcase
      bus(we, a, d, s, r);
      if (!we) check(tag, r, e);
      else
         case (a)
            3'd1: if (s[0]) begin
               if (txq.size() < 16) txq.push_back(d[7:0]);
               else m_tx_ovf = 1;
            end
            3'd2: begin
               if (d[4]) m_rx_ovr = 0;
               if (d[5]) m_frm = 0;
               if (d[6]) m_tx_ovf = 0;
            end
            3'd3: begin
               if (s[0]) m_en = d[2:0];
               if (s[1]) m_thr = d[15:8];
            end
            3'd4: begin
               nd = {s[1] ? d[15:8] : m_div[15:8], s[0] ? d[7:0] : m_div[7:0]};
               if (nd != 0) m_div = nd;
            end
            default: ;
         endcase
   endtask

   task automatic rxin(input logic [7:0] b, input logic fe);
      @(negedge clk);
      i_rx_valid = 1; i_rx_data = b; i_frame_err = fe;
      @(negedge clk);
      i_rx_valid = 0; i_frame_err = 0;
      if (fe) m_frm = 1;
      else if (rxq.size() == 16) m_rx_ovr = 1;
      else rxq.push_back(b);
   endtask

   task automatic serve();
      logic [7:0] e;
      e = txq.pop_front();
      tx_idle = 0;
      @(negedge clk);
      i_tx_busy = 0;
      for (int k = 0; k < 8 && !o_tx_start; k++) @(negedge clk);
      check("tx_start_rise", o_tx_start, 1);
      check("tx_data", o_tx_data, e);
      idle(3);
      check("tx_start_hold", o_tx_start, 1);
      check("tx_data_stable", o_tx_data, e);
      i_tx_busy = 1; i_tx_start_clear = 1;
      @(negedge clk);
      i_tx_start_clear = 0;
      check("tx_start_drop", o_tx_start, 0);
      idle(2);
   endtask

   task automatic release_tx();
      @(negedge clk);
      i_tx_busy = 0;
      idle(2);
      tx_idle = 1;
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0] b, e;
      int n;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", o_wb_ack, 0);
      check("rst_dat", o_wb_dat, 0);
      check("rst_tx_start", o_tx_start, 0);
      check("rst_tx_data", o_tx_data, 0);
      check("rst_irq", o_irq, 0);
      check("rst_clk_div", o_clk_div, 16'd4167);
      @(negedge clk);
      rst_n = 1;
      access(0, 3'd4, 0, 4'hF, "rd_clkdiv_reset");
      access(0, 3'd2, 0, 4'hF, "rd_status_reset");
      check("status_reset_const", m_status(), 32'h5);

      // TX: three fixed bytes held back by a busy transmitter, then sent in order
      i_tx_busy = 1;
      access(1, 3'd1, 32'h41, 4'h1, "wr_tx");
      access(1, 3'd1, 32'h42, 4'h1, "wr_tx");
      access(1, 3'd1, 32'h43, 4'h1, "wr_tx");
      access(0, 3'd2, 0, 4'hF, "status_tx3");
      repeat (3) serve();
      release_tx();
      access(0, 3'd2, 0, 4'hF, "status_tx0");
      // TX: random burst, a byte lane 0 disabled write is ignored
      i_tx_busy = 1;
      n = $urandom_range(4, 8);
      for (int i = 0; i < n; i++) access(1, 3'd1, $urandom, 4'hF, "wr_tx_rand");
      access(1, 3'd1, 32'hEE, 4'hE, "wr_tx_nosel");
      access(0, 3'd2, 0, 4'hF, "status_tx_rand");
      while (txq.size() != 0) serve();
      release_tx();
      // TX overflow
      i_tx_busy = 1;
      for (int i = 0; i < 17; i++) access(1, 3'd1, $urandom, 4'h1, "wr_tx_ovf");
      access(0, 3'd2, 0, 4'hF, "status_tx_full_ovf");
      access(1, 3'd2, 32'h40, 4'hF, "w1c_tx_ovf");
      access(0, 3'd2, 0, 4'hF, "status_tx_ovf_clr");
      while (txq.size() != 0) serve();
      release_tx();
      // TX empty/idle interrupt
      access(1, 3'd3, 32'h2, 4'h1, "wr_ctrl_txen");
      idle(2);
      check("irq_tx_idle", o_irq, m_irq());
      i_tx_busy = 1;
      access(1, 3'd1, $urandom, 4'h1, "wr_tx_irq");
      idle(2);
      check("irq_tx_nonempty", o_irq, m_irq());
      serve();
      release_tx();
      idle(1);
      check("irq_tx_idle_again", o_irq, m_irq());
      access(1, 3'd3, 32'h0, 4'hF, "wr_ctrl_off");

      // RX: 17 bytes into a 16-deep FIFO
      for (int i = 0; i <= 16; i++) rxin(8'(i), 0);
      access(0, 3'd2, 0, 4'hF, "status_rx_full_ovr");
      for (int i = 0; i < 17; i++) access(0, 3'd0, 0, 4'hF, "rd_rx_seq");
      access(0, 3'd2, 0, 4'hF, "status_rx_drained");
      access(1, 3'd2, 32'h10, 4'hF, "w1c_rx_ovr");
      access(0, 3'd2, 0, 4'hF, "status_rx_ovr_clr");
      // RX: pop and push in the same cycle while full
      for (int i = 0; i < 16; i++) rxin(8'($urandom), 0);
      b = 8'($urandom);
      idle(2);
      e = rxq.pop_front();
      i_wb_valid = 1; i_wb_we = 0; i_wb_adr = 32'h0; i_wb_sel = 4'hF;
      i_rx_valid = 1; i_rx_data = b;
      @(posedge clk);
      #1;
      check("simul_ack", o_wb_ack, 1);
      check("simul_rd", o_wb_dat, {23'h0, 1'b1, e});
      i_wb_valid = 0; i_rx_valid = 0;
      rxq.push_back(b);
      access(0, 3'd2, 0, 4'hF, "status_simul_no_ovr");
      while (rxq.size() != 0) access(0, 3'd0, 0, 4'hF, "rd_rx_drain");
      // RX: random mix of arrivals, frame errors and reads
      for (int i = 0; i < 40; i++)
         if ($urandom_range(0, 1) == 1) rxin(8'($urandom), $urandom_range(0, 7) == 0);
         else access(0, 3'd0, 0, 4'hF, "rd_rx_rand");
      access(0, 3'd2, 0, 4'hF, "status_rx_rand");
      while (rxq.size() != 0) access(0, 3'd0, 0, 4'hF, "rd_rx_drain2");
      access(0, 3'd0, 0, 4'hF, "rd_rx_empty");
      access(1, 3'd2, 32'h70, 4'hF, "w1c_all");
      access(0, 3'd2, 0, 4'hF, "status_clean");

      // RX threshold interrupt
      access(1, 3'd3, 32'h0401, 4'h3, "wr_ctrl_thr4");
      for (int i = 0; i < 3; i++) rxin(8'($urandom), 0);
      idle(1);
      check("irq_below_thr", o_irq, 0);
      rxin(8'($urandom), 0);
      check("irq_lag", o_irq, 0);
      @(negedge clk);
      check("irq_at_thr", o_irq, 1);
      check("irq_model_thr", o_irq, m_irq());
      access(0, 3'd0, 0, 4'hF, "rd_rx_irq");
      idle(2);
      check("irq_after_pop", o_irq, 0);
      access(1, 3'd3, 32'h0, 4'h2, "wr_ctrl_thr0");
      idle(2);
      check("irq_thr0_as_1", o_irq, m_irq());
      while (rxq.size() != 0) access(0, 3'd0, 0, 4'hF, "rd_rx_drain3");
      idle(2);
      check("irq_thr0_empty", o_irq, 0);
      access(0, 3'd3, 0, 4'hF, "rd_ctrl");
      access(1, 3'd3, 32'h0, 4'hF, "wr_ctrl_off2");

      // frame error
      rxin(8'h55, 1);
      access(0, 3'd2, 0, 4'hF, "status_frm_err");
      access(1, 3'd3, 32'h4, 4'h1, "wr_ctrl_erren");
      idle(2);
      check("irq_err", o_irq, 1);
      access(1, 3'd2, 32'h20, 4'hF, "w1c_frm");
      idle(2);
      check("irq_err_clr", o_irq, 0);
      access(0, 3'd2, 0, 4'hF, "status_frm_clr");

      // CLKDIV byte enables and zero-write protection
      access(1, 3'd4, 32'h12, 4'h1, "wr_div_lo");
      check("clk_div_0x1012", o_clk_div, 16'h1012);
      access(1, 3'd4, 32'h0, 4'hF, "wr_div_zero");
      check("clk_div_hold", o_clk_div, 16'h1012);
      for (int i = 0; i < 8; i++) begin
         d = (i % 3 == 0) ? 32'h0 : $urandom;
         access(1, 3'd4, d, 4'($urandom_range(0, 15)), "wr_div_rand");
         check("clk_div_rand", o_clk_div, m_div);
         access(0, 3'd4, 0, 4'hF, "rd_div_rand");
      end
      for (int i = 0; i < 4; i++) begin
         access(1, 3'd3, $urandom & 32'hFFFF_FFF8, 4'($urandom_range(0, 15)), "wr_ctrl_rand");
         access(0, 3'd3, 0, 4'hF, "rd_ctrl_rand");
      end
      access(1, 3'd3, 32'h0, 4'hF, "wr_ctrl_off3");
      // unmapped offsets and write-only TXDATA read back as zero
      for (int a = 5; a < 8; a++) begin
         access(1, 3'(a), $urandom, 4'hF, "wr_unmapped");
         access(0, 3'(a), 0, 4'hF, "rd_unmapped");
      end
      access(0, 3'd1, 0, 4'hF, "rd_txdata");
      access(0, 3'd2, 0, 4'hF, "status_after_unmapped");

      // reset while a byte is in flight
      access(1, 3'd3, 32'h4, 4'hF, "wr_ctrl_erren2");
      rxin(8'hAA, 1);
      idle(1);
      check("irq_before_rst", o_irq, 1);
      i_tx_busy = 1;
      access(1, 3'd1, 32'h5A, 4'h1, "wr_tx_midrst");
      @(negedge clk);
      i_tx_busy = 0;
      for (int k = 0; k < 8 && !o_tx_start; k++) @(negedge clk);
      check("midrst_start", o_tx_start, 1);
      check("midrst_data", o_tx_data, 8'h5A);
      #2 rst_n = 0;
      #1;
      check("midrst_tx_start", o_tx_start, 0);
      check("midrst_tx_data", o_tx_data, 0);
      check("midrst_clk_div", o_clk_div, 16'd4167);
      check("midrst_irq", o_irq, 0);
      check("midrst_ack", o_wb_ack, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      access(0, 3'd2, 0, 4'hF, "status_after_rst");
      access(0, 3'd4, 0, 4'hF, "clkdiv_after_rst");
      access(0, 3'd3, 0, 4'hF, "ctrl_after_rst");
      idle(3);
      check("tx_start_after_rst", o_tx_start, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
